// File: rtl/spi_adc7476_rx_if.sv
// Signal bundle between the AD7476 receiver and its surroundings.
// Master side is the receiver: it drives chip select, serial clock and sample outputs.
// Slave side is the ADC plus downstream consumers: they drive the start strobe and serial data.
interface spi_adc7476_rx_if;
  logic        st;
  logic        SDATA;
  logic        NCS;
  logic        SCLK;
  logic [11:0] DO;
  logic        ok;
  logic        busy;
  logic        err;

  modport master (
    input  st, SDATA,
    output NCS, SCLK, DO, ok, busy, err
  );

  modport slave (
    output st, SDATA,
    input  NCS, SCLK, DO, ok, busy, err
  );
endinterface

// File: rtl/spi_adc7476_rx.sv
// SPI master receiver for a 12-bit AD7476-style ADC: one 16-bit frame per accepted st strobe.
// Latency: ok pulses 1+33*DIV clk cycles after the accepted st; busy clears QUIET cycles later.
// No backpressure: st is ignored while busy. Optional macro ADC_TWOS_COMP_EN converts DO to two's complement.
module spi_adc7476_rx #(
  parameter int DIV   = 2,
  parameter int QUIET = 4
) (
  input logic               clk,
  input logic               rst,
  spi_adc7476_rx_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_QUIET
  } state_t;

  // One down-counter-free cycle counter is shared by SETUP, the SCLK half-periods and QUIET.
  localparam int CMAX = (DIV > QUIET) ? DIV : QUIET;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt,   w_cnt;
  logic [3:0]    r_bit,   w_bit;
  logic [15:0]   r_shift, w_shift;
  logic          r_ncs,   w_ncs;
  logic          r_sclk,  w_sclk;
  logic [11:0]   r_do,    w_do;
  logic          r_ok,    w_ok;
  logic          r_busy,  w_busy;
  logic          r_err,   w_err;
  logic [11:0]   w_sample;

  // The 12 data bits of the frame are the low bits of the shift register once bit 15 is in.
`ifdef ADC_TWOS_COMP_EN
  // Straight binary to two's complement: mid-scale becomes zero.
  assign w_sample = {~r_shift[11], r_shift[10:0]};
`else
  assign w_sample = r_shift[11:0];
`endif

  // State and all outputs are registered so NCS/SCLK leave the block glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b1;
      r_do    <= '0;
      r_ok    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_ncs   <= w_ncs;
      r_sclk  <= w_sclk;
      r_do    <= w_do;
      r_ok    <= w_ok;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end

  // Next-state and next-output logic; SDATA is captured on the edge that raises SCLK.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_ncs   = r_ncs;
    w_sclk  = r_sclk;
    w_do    = r_do;
    w_err   = r_err;
    w_busy  = r_busy;
    w_ok    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ncs  = 1'b1;
        w_sclk = 1'b1;
        w_busy = 1'b0;
        w_cnt  = '0;
        if (bus.st) begin
          w_state = S_SETUP;
          w_ncs   = 1'b0;
          w_busy  = 1'b1;
        end
      end

      S_SETUP: begin
        if (r_cnt == DIV_LAST) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_bit   = '0;
          w_sclk  = 1'b0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_SHIFT: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt = '0;
          if (!r_sclk) begin
            // End of the low phase: SCLK rises and the ADC bit is stable.
            w_sclk  = 1'b1;
            w_shift = {r_shift[14:0], bus.SDATA};
          end else if (r_bit == 4'd15) begin
            // High phase of the last bit closes the frame.
            w_state = S_QUIET;
            w_ncs   = 1'b1;
            w_do    = w_sample;
            w_err   = |r_shift[15:12];
            w_ok    = 1'b1;
          end else begin
            w_bit  = r_bit + 4'd1;
            w_sclk = 1'b0;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_QUIET: begin
        w_ncs  = 1'b1;
        w_sclk = 1'b1;
        if (r_cnt == QUIET_LAST) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_busy  = 1'b0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.NCS  = r_ncs;
  assign bus.SCLK = r_sclk;
  assign bus.DO   = r_do;
  assign bus.ok   = r_ok;
  assign bus.busy = r_busy;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_spi_adc7476_rx.sv
// Bench for spi_adc7476_rx: instance A (DIV=2, QUIET=4) for directed timing cases,
// instance B (DIV=1, QUIET=1) for a 100-sample random stream at one strobe per 36 cycles.
// Each ADC model plays queued 16-bit frames; a scoreboard compares DO/err on every ok.
module tb_spi_adc7476_rx;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  spi_adc7476_rx_if a_if ();
  spi_adc7476_rx_if b_if ();

  spi_adc7476_rx #(.DIV(2), .QUIET(4)) u_a (.clk(clk), .rst(rst), .bus(a_if.master));
  spi_adc7476_rx #(.DIV(1), .QUIET(1)) u_b (.clk(clk), .rst(rst), .bus(b_if.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Expected DO for a 16-bit ADC frame: the 12 data bits, offset by half-scale when signed.
  function automatic logic [11:0] exp_do(input logic [15:0] w);
    int v;
    v = int'(w[11:0]);
`ifdef ADC_TWOS_COMP_EN
    v = v - 2048;
`endif
    return 12'(v);
  endfunction

  // ---------------- ADC models: frame bit (15-k+1) driven after the k-th SCLK fall ----------------
  logic [15:0] a_q[$], a_sent[$], b_q[$], b_sent[$];
  logic [15:0] a_word, b_word;
  int a_k = 0, b_k = 0;

  always @(negedge a_if.SCLK or posedge a_if.NCS) begin
    if (a_if.NCS) a_k = 0;
    else begin
      if (a_k == 0) begin
        a_word = (a_q.size() > 0) ? a_q.pop_front() : 16'h0000;
        a_sent.push_back(a_word);
      end
      a_k++;
      if (a_k <= 16) a_if.SDATA = a_word[16 - a_k];
    end
  end

  always @(negedge b_if.SCLK or posedge b_if.NCS) begin
    if (b_if.NCS) b_k = 0;
    else begin
      if (b_k == 0) begin
        b_word = (b_q.size() > 0) ? b_q.pop_front() : 16'h0000;
        b_sent.push_back(b_word);
      end
      b_k++;
      if (b_k <= 16) b_if.SDATA = b_word[16 - b_k];
    end
  end

  // ---------------- monitors (sampled on the falling clk edge) ----------------
  int a_ok_cnt = 0, a_ok_cyc = 0, a_rise = 0;
  int b_ok_cnt = 0, b_ok_cyc = 0, b_last_rise = 0;
  logic a_sclk_q = 1'b1, b_sclk_q = 1'b1, b_first = 1'b1;
  logic [12:0] a_hold = '0, b_hold = '0;

  always @(negedge clk) begin
    logic [15:0] w;
    if (rst) a_sent.delete();
    if (a_if.ok) begin
      a_ok_cnt++;
      a_ok_cyc = cyc;
      if (a_sent.size() == 0) chk("a_ok_unexpected", 1, 0);
      else begin
        w = a_sent.pop_front();
        chk("a_do", a_if.DO, exp_do(w));
        chk("a_err", a_if.err, |w[15:12]);
      end
    end else if (!rst) begin
      chk("a_do_err_hold", {a_if.err, a_if.DO}, a_hold);
    end
    a_hold = {a_if.err, a_if.DO};
    if (!a_if.NCS && a_if.SCLK && !a_sclk_q) a_rise++;
    a_sclk_q = a_if.SCLK;
  end

  always @(negedge clk) begin
    logic [15:0] w;
    if (rst) b_sent.delete();
    if (b_if.ok) begin
      b_ok_cnt++;
      b_ok_cyc = cyc;
      if (b_sent.size() == 0) chk("b_ok_unexpected", 1, 0);
      else begin
        w = b_sent.pop_front();
        chk("b_do", b_if.DO, exp_do(w));
        chk("b_err", b_if.err, |w[15:12]);
      end
    end else if (!rst) begin
      chk("b_do_err_hold", {b_if.err, b_if.DO}, b_hold);
    end
    b_hold = {b_if.err, b_if.DO};
    if (b_if.NCS) b_first = 1'b1;
    else if (b_if.SCLK && !b_sclk_q) begin
      if (!b_first) chk("b_sclk_period", cyc - b_last_rise, 2);
      b_last_rise = cyc;
      b_first = 1'b0;
    end
    b_sclk_q = b_if.SCLK;
  end

  // ---------------- stimulus helpers ----------------
  int a_st_cyc = 0, b_st_cyc = 0;

  task automatic a_pulse();
    @(posedge clk); #1;
    a_if.st = 1'b1;
    a_st_cyc = cyc;
    @(posedge clk); #1;
    a_if.st = 1'b0;
  endtask

  task automatic b_pulse();
    @(posedge clk); #1;
    b_if.st = 1'b1;
    b_st_cyc = cyc;
    @(posedge clk); #1;
    b_if.st = 1'b0;
  endtask

  task automatic a_wait_ok(input int base, input int budget);
    int n = 0;
    while (a_ok_cnt <= base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (a_ok_cnt <= base) chk("a_ok_timeout", 0, 1);
  endtask

  task automatic a_wait_idle(input int budget);
    int n = 0;
    while (a_if.busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (a_if.busy) chk("a_idle_timeout", 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, r0, t0;
    rst = 1'b1;
    a_if.st = 1'b0;
    b_if.st = 1'b0;
    #1;
    chk("rst_ncs",  a_if.NCS, 1);
    chk("rst_sclk", a_if.SCLK, 1);
    chk("rst_do",   a_if.DO, 0);
    chk("rst_ok",   a_if.ok, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_err",  a_if.err, 0);
    chk("rst_b_ncs_sclk", {b_if.NCS, b_if.SCLK}, 2'b11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset during bit 7 of the shift phase aborts the frame immediately.
    base = a_ok_cnt;
    a_q.push_back(16'h0123);
    a_pulse();
    repeat (31) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_ncs",  a_if.NCS, 1);
    chk("abort_sclk", a_if.SCLK, 1);
    chk("abort_do",   a_if.DO, 0);
    chk("abort_busy", a_if.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_ok", a_ok_cnt - base, 0);
    chk("abort_do_kept", a_if.DO, 0);

    // Normal frame 0x0A5A: latency, SCLK edge count, DO and err.
    base = a_ok_cnt;
    r0 = a_rise;
    a_q.push_back(16'h0A5A);
    a_pulse();
    chk("a_busy_c1", a_if.busy, 1);
    chk("a_ncs_c1",  a_if.NCS, 0);
    a_wait_ok(base, 200);
    chk("a_ok_latency", a_ok_cyc - a_st_cyc, 67);
    chk("a_sclk_rises", a_rise - r0, 16);
    chk("a_do_a5a", a_if.DO, exp_do(16'h0A5A));
    chk("a_err_clear", a_if.err, 0);
    a_wait_idle(100);

    // Leading bits 0100 with full-scale data: err set with ok.
    base = a_ok_cnt;
    a_q.push_back(16'h4FFF);
    a_pulse();
    a_wait_ok(base, 200);
    chk("a_do_fff", a_if.DO, exp_do(16'h4FFF));
    chk("a_err_lead", a_if.err, 1);
    a_wait_idle(100);

    // A second st 20 cycles into a frame is ignored; a st on the first idle cycle is taken.
    base = a_ok_cnt;
    a_q.push_back(16'(($urandom) & 32'h0FFF));
    a_pulse();
    t0 = a_st_cyc;
    repeat (18) @(posedge clk);
    a_pulse();
    a_wait_ok(base, 200);
    chk("a_ignored_latency", a_ok_cyc - t0, 67);
    a_wait_idle(100);
    chk("a_busy_len", cyc - t0, 71);
    a_q.push_back(16'($urandom));
    a_if.st = 1'b1;
    a_st_cyc = cyc;
    @(posedge clk); #1;
    a_if.st = 1'b0;
    chk("a_restart_ncs",  a_if.NCS, 0);
    chk("a_restart_busy", a_if.busy, 1);
    a_wait_ok(base + 1, 200);
    chk("a_restart_latency", a_ok_cyc - a_st_cyc, 67);
    chk("a_two_oks", a_ok_cnt - base, 2);
    a_wait_idle(100);

    // st held for three cycles in idle starts exactly one frame.
    base = a_ok_cnt;
    a_q.push_back(16'($urandom));
    @(posedge clk); #1;
    a_if.st = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    a_if.st = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("a_held_one_ok", a_ok_cnt - base, 1);
    chk("a_held_q_used", a_q.size(), 0);

    // Random stream on instance B at one strobe every 36 cycles.
    for (int i = 0; i < 100; i++) b_q.push_back(16'($urandom));
    for (int i = 0; i < 100; i++) begin
      b_pulse();
      repeat (33) @(posedge clk);
      #1;
      chk("b_ok_at_34", b_if.ok, 1);
      @(posedge clk);
    end
    repeat (50) @(posedge clk);
    #1;
    chk("b_ok_count", b_ok_cnt, 100);
    chk("b_all_consumed", b_sent.size() + b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=<200000ns", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_adc7476_rx.md
Name: spi_adc7476_rx

Overview:
- SPI master receiver for a 12-bit AD7476-style serial ADC on a Pmod header.
- Converts an external analog signal into a 12-bit sample word `DO`, which feeds the measurement path as an alternative source to the internal generator.
- Downstream consumers are the signal mux and the RMS/peak block.
- One conversion is started per `st` strobe (normally the microsecond clock-enable).
- A one-cycle `ok` pulse accompanies each new sample.

Parameters:
- DIV, 2, SCLK half-period in clk cycles (>=1); SCLK = clk/(2*DIV).
- QUIET, 4, minimum NCS-high quiet time in clk cycles after a transfer before a new `st` is accepted (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- st  input  1  start strobe, one clk wide; ignored unless idle.
- SDATA  input  1  serial data from ADC; ADC changes it on SCLK falling edge.
- NCS  output  1  ADC chip select, active-low.
- SCLK  output  1  serial clock to ADC; idles high.
- DO  output  12  last completed sample; held between conversions.
- ok  output  1  one-cycle pulse when DO updates.
- busy  output  1  high from `st` acceptance until the quiet time ends.
- err  output  1  leading-zero check of the last frame; 1 = a leading bit was 1.

Behaviour:
- Reset (async, immediate): NCS=1, SCLK=1, DO=0, ok=0, busy=0, err=0, state=IDLE, counters cleared.
- Reset mid-transfer aborts the transfer immediately. No `ok` is issued. DO keeps 0.
- States: IDLE, SETUP, SHIFT, QUIET.
- IDLE:
  - NCS=1, SCLK=1.
  - `st`=1 at cycle 0 → SETUP; busy=1 and NCS=0 from cycle 1.
- SETUP:
  - NCS=0, SCLK=1, lasts DIV cycles.
  - Then → SHIFT, bit counter=0.
- SHIFT: 16 bit periods, each 2*DIV cycles.
  - SCLK is low for the first DIV cycles, then high for the next DIV cycles.
  - SDATA is sampled into a 16-bit shift register (MSB first) on the clk edge where SCLK goes 0→1.
- End of SHIFT, on the clk edge closing the high phase of bit 15:
  - NCS←1.
  - DO←shift[11:0].
  - err←|shift[15:12].
  - ok=1 for exactly one cycle.
  - → QUIET.
- `ok` timing: `ok` is asserted on cycle 1+33*DIV relative to the accepted `st` (DIV=2: cycle 67).
- QUIET:
  - NCS=1, SCLK=1, lasts QUIET cycles.
  - Then busy=0 → IDLE.
  - The first `st` accepted is on the cycle after busy falls.
- `st` while busy=1 is ignored entirely: not queued, no effect on timing or counters.
- `st` asserted for several consecutive cycles: only the first cycle in IDLE starts a transfer. Subsequent cycles fall in busy and are ignored.
- Minimum `st` period for no lost strobes: 1+33*DIV+QUIET cycles. The integrator picks DIV and the strobe rate accordingly.
- SCLK and NCS are registered outputs, glitch-free.
- DO and err change only on the `ok` cycle.

Optional Feature:
- Macro: ADC_TWOS_COMP_EN.
- Defined: DO is the sample converted from straight binary to 12-bit two's complement, by inverting bit 11 (mid-scale 0x800 → 0x000, 0xFFF → 0x7FF, 0x000 → 0x800). This matches the signed generator samples at the mux input.
- Not defined: DO is the raw straight-binary ADC code.
- Timing, `ok` and `err` are identical in both builds.

Test Plan:
- Reset mid-SHIFT (assert rst during bit 7) → NCS=1 and SCLK=1 asynchronously; no `ok` pulse; DO=0; after release, next `st` yields a normal transfer.
- DIV=2, QUIET=4, ADC model drives 0000_1010_0101_1010 → `ok` on cycle 67 after `st`; DO=0xA5A (0x25A with ADC_TWOS_COMP_EN); err=0; exactly 16 SCLK rising edges while NCS=0.
- Model drives leading bits 0100 with data 0xFFF → DO=0xFFF (0x7FF with _EN), err=1 coincident with `ok`.
- Second `st` issued 20 cycles after the first → ignored; only one `ok`. `st` issued on the cycle after busy falls → accepted, NCS low on the following cycle.
- `st` held high for 3 cycles in IDLE → exactly one transfer and one `ok`.
- DIV=1, QUIET=1, back-to-back `st` every 36 cycles, 100 random samples → every sample received in order; DO matches the model each `ok`; SCLK period = 2 clk.
